vector_halves_collect_10: RTL and testbench



---
 rtl/vector_halves_collect_10_pkg.sv | 8 +
 rtl/vector_halves_collect_10_half_vector_reg_5.sv | 15 +
 rtl/vector_halves_collect_10.sv | 74 +++++++
 tb/tb_vector_halves_collect_10.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/vector_halves_collect_10_pkg.sv
// vector_halves_collect_10_pkg: shared state type, widths and series encodings
package vector_halves_collect_10_pkg;
  typedef enum logic {WAIT_LO = 1'b0, WAIT_HI = 1'b1} state_t;
  localparam int DEFAULT_IN_WIDTH = 11;
  localparam int DEFAULT_CNT_WIDTH = 16;
  localparam logic SERIES_LO = 1'b0;
  localparam logic SERIES_HI = 1'b1;
endpackage

// File: rtl/vector_halves_collect_10_half_vector_reg_5.sv
// half_vector_reg_5: five-element signed register bank with load and enable
module half_vector_reg_5 #(
  parameter int IN_WIDTH = vector_halves_collect_10_pkg::DEFAULT_IN_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       load,
  input  logic signed [IN_WIDTH-1:0] d [5],
  output logic signed [IN_WIDTH-1:0] q [5]
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) q <= '{default: '0};
    else if (enable && load) q <= d;
endmodule

// File: rtl/vector_halves_collect_10.sv
// vector_halves_collect_10: pairs two series-tagged half beats into one ten-element vector
module vector_halves_collect_10
  import vector_halves_collect_10_pkg::*;
#(
  parameter int IN_WIDTH = DEFAULT_IN_WIDTH,
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic                        inReady,
  input  logic                        inSeries,
  input  logic signed [IN_WIDTH-1:0]  D0,
  input  logic signed [IN_WIDTH-1:0]  D1,
  input  logic signed [IN_WIDTH-1:0]  D2,
  input  logic signed [IN_WIDTH-1:0]  D3,
  input  logic signed [IN_WIDTH-1:0]  D4,
  output logic signed [IN_WIDTH-1:0]  Y0,
  output logic signed [IN_WIDTH-1:0]  Y1,
  output logic signed [IN_WIDTH-1:0]  Y2,
  output logic signed [IN_WIDTH-1:0]  Y3,
  output logic signed [IN_WIDTH-1:0]  Y4,
  output logic signed [IN_WIDTH-1:0]  Y5,
  output logic signed [IN_WIDTH-1:0]  Y6,
  output logic signed [IN_WIDTH-1:0]  Y7,
  output logic signed [IN_WIDTH-1:0]  Y8,
  output logic signed [IN_WIDTH-1:0]  Y9,
  output logic                        outReady,
  output logic                        readyForNewDataSeries,
  output logic                        seriesError,
  output logic [CNT_WIDTH-1:0]        vectorCount
);
  state_t state, nextState;
  logic beatLo, beatHi, complete, misaligned;
  logic signed [IN_WIDTH-1:0] dIn [5];
  logic signed [IN_WIDTH-1:0] lowQ [5];
  logic signed [IN_WIDTH-1:0] yLo [5];
  logic signed [IN_WIDTH-1:0] yHi [5];
  assign dIn = '{D0, D1, D2, D3, D4};
  assign beatLo = inReady && inSeries == SERIES_LO;
  assign beatHi = inReady && inSeries == SERIES_HI;
  assign complete = beatHi && state == WAIT_HI;
  assign misaligned = state == WAIT_LO ? beatHi : beatLo;
  assign readyForNewDataSeries = state == WAIT_LO;
  always_comb begin
    nextState = state;
    nextState = beatLo ? WAIT_HI : complete ? WAIT_LO : state;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= WAIT_LO;
    else if (enable) state <= nextState;
  // A low beat always reloads the buffer, so a resync keeps the newest first half
  half_vector_reg_5 #(.IN_WIDTH(IN_WIDTH)) lowBuf (
    .clk(clk), .reset_n(reset_n), .enable(enable), .load(beatLo), .d(dIn), .q(lowQ)
  );
  half_vector_reg_5 #(.IN_WIDTH(IN_WIDTH)) outLo (
    .clk(clk), .reset_n(reset_n), .enable(enable), .load(complete), .d(lowQ), .q(yLo)
  );
  half_vector_reg_5 #(.IN_WIDTH(IN_WIDTH)) outHi (
    .clk(clk), .reset_n(reset_n), .enable(enable), .load(complete), .d(dIn), .q(yHi)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      outReady <= 1'b0;
      seriesError <= 1'b0;
      vectorCount <= '0;
    end else if (enable) begin
      outReady <= complete;
      seriesError <= seriesError | misaligned;
      vectorCount <= vectorCount + CNT_WIDTH'(complete);
    end
  assign {Y0, Y1, Y2, Y3, Y4} = {yLo[0], yLo[1], yLo[2], yLo[3], yLo[4]};
  assign {Y5, Y6, Y7, Y8, Y9} = {yHi[0], yHi[1], yHi[2], yHi[3], yHi[4]};
endmodule

// File: tb/tb_vector_halves_collect_10.sv
// tb_vector_halves_collect_10: scoreboard bench for the half-vector collector
module tb_vector_halves_collect_10;
  localparam int W = 11;
  localparam int CW = 2;
  typedef struct packed {
    logic [10*W-1:0] y;
    logic [CW-1:0] cnt;
  } exp_t;
  logic clk = 0, reset_n = 0, enable = 0, inReady = 0, inSeries = 0;
  logic signed [W-1:0] D0 = 0, D1 = 0, D2 = 0, D3 = 0, D4 = 0;
  logic signed [W-1:0] Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7, Y8, Y9;
  logic outReady, readyForNewDataSeries, seriesError;
  logic [CW-1:0] vectorCount;
  logic [10*W-1:0] yAct;
  exp_t sb[$];
  int asserts = 0, fails = 0, pulses = 0, cycle = 0;
  int pulseAt[$];
  always #5 clk = ~clk;
  vector_halves_collect_10 #(.IN_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .inReady(inReady), .inSeries(inSeries),
    .D0(D0), .D1(D1), .D2(D2), .D3(D3), .D4(D4),
    .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3), .Y4(Y4), .Y5(Y5), .Y6(Y6), .Y7(Y7), .Y8(Y8), .Y9(Y9),
    .outReady(outReady), .readyForNewDataSeries(readyForNewDataSeries),
    .seriesError(seriesError), .vectorCount(vectorCount)
  );
  assign yAct = {Y9, Y8, Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0};
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [10*W-1:0] pk(input int v[10]);
    logic [10*W-1:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) r[i*W +: W] = W'(v[i]);
    return r;
  endfunction
  task automatic push(input int v[10], input int c);
    exp_t e;
    e.y = pk(v);
    e.cnt = CW'(c);
    sb.push_back(e);
  endtask
  task automatic drive(input logic en, input logic rdy, input logic ser, input int v[5]);
    enable = en; inReady = rdy; inSeries = ser;
    D0 = W'(v[0]); D1 = W'(v[1]); D2 = W'(v[2]); D3 = W'(v[3]); D4 = W'(v[4]);
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, '{0, 0, 0, 0, 0});
  endtask
  initial begin : monitor
    logic enSeen;
    exp_t e;
    forever begin
      @(posedge clk);
      cycle++;
      enSeen = enable && reset_n;
      #1;
      if (outReady && enSeen) begin
        pulses++;
        pulseAt.push_back(cycle);
        if (sb.size() == 0) chk("unexpected_outReady", 1, 0);
        else begin
          e = sb.pop_front();
          chk("Y_vector", yAct, e.y);
          chk("vectorCount", vectorCount, e.cnt);
        end
      end
    end
  end
  initial begin
    int p;
    @(negedge clk);
    chk("reset_Y", yAct, 0);
    chk("reset_outReady", outReady, 0);
    chk("reset_rfnds", readyForNewDataSeries, 1);
    chk("reset_seriesError", seriesError, 0);
    chk("reset_vectorCount", vectorCount, 0);
    reset_n = 1;
    idle(1);
    // normal vector
    push('{1, 2, 3, 4, 5, -1, -2, -3, -4, -1024}, 1);
    drive(1, 1, 0, '{1, 2, 3, 4, 5});
    chk("after_lo_rfnds", readyForNewDataSeries, 0);
    drive(1, 1, 1, '{-1, -2, -3, -4, -1024});
    idle(2);
    chk("normal_pulses", pulses, 1);
    // back-to-back
    push('{11, 12, 13, 14, 15, 16, 17, 18, 19, 20}, 2);
    push('{-5, 6, -7, 8, -9, 1023, -1023, 0, 1, -1}, 3);
    drive(1, 1, 0, '{11, 12, 13, 14, 15});
    drive(1, 1, 1, '{16, 17, 18, 19, 20});
    drive(1, 1, 0, '{-5, 6, -7, 8, -9});
    drive(1, 1, 1, '{1023, -1023, 0, 1, -1});
    idle(2);
    chk("b2b_pulses", pulses, 3);
    chk("b2b_gap", pulseAt[2] - pulseAt[1], 2);
    chk("b2b_no_error", seriesError, 0);
    // misalignment
    drive(1, 1, 1, '{7, 7, 7, 7, 7});
    idle(1);
    chk("misalign_error", seriesError, 1);
    chk("misalign_rfnds", readyForNewDataSeries, 1);
    chk("misalign_no_pulse", pulses, 3);
    push('{20, 21, 22, 23, 24, 30, 31, 32, 33, 34}, 0);
    drive(1, 1, 0, '{10, 11, 12, 13, 14});
    drive(1, 1, 0, '{20, 21, 22, 23, 24});
    drive(1, 1, 1, '{30, 31, 32, 33, 34});
    idle(2);
    chk("resync_pulses", pulses, 4);
    // enable stall with spurious beats, then held outReady
    push('{40, 41, 42, 43, 44, 50, 51, 52, 53, 54}, 1);
    drive(1, 1, 0, '{40, 41, 42, 43, 44});
    for (int i = 0; i < 3; i++) drive(0, 1, 1, '{99, 98, 97, 96, 95});
    chk("stall_rfnds", readyForNewDataSeries, 0);
    chk("stall_no_pulse", pulses, 4);
    drive(1, 1, 1, '{50, 51, 52, 53, 54});
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, '{0, 0, 0, 0, 0});
      chk("stall_outReady_held", outReady, 1);
    end
    idle(2);
    chk("stall_pulses", pulses, 5);
    chk("stall_outReady_cleared", outReady, 0);
    // async reset mid-vector
    drive(1, 1, 0, '{60, 61, 62, 63, 64});
    @(posedge clk);
    #2 reset_n = 0;
    #1;
    chk("areset_Y", yAct, 0);
    chk("areset_seriesError", seriesError, 0);
    chk("areset_vectorCount", vectorCount, 0);
    chk("areset_rfnds", readyForNewDataSeries, 1);
    chk("areset_outReady", outReady, 0);
    @(negedge clk);
    reset_n = 1;
    drive(1, 1, 1, '{70, 71, 72, 73, 74});
    idle(1);
    chk("post_reset_error", seriesError, 1);
    chk("post_reset_no_pulse", pulses, 5);
    // counter wrap over five vectors
    for (int k = 0; k < 5; k++) begin
      push('{k, k + 1, k + 2, k + 3, k + 4, -k, -k - 1, -k - 2, -k - 3, -k - 4}, (k + 1) % 4);
      drive(1, 1, 0, '{k, k + 1, k + 2, k + 3, k + 4});
      drive(1, 1, 1, '{-k, -k - 1, -k - 2, -k - 3, -k - 4});
    end
    idle(3);
    chk("wrap_vectorCount", vectorCount, 1);
    chk("wrap_pulses", pulses, 10);
    p = sb.size();
    chk("scoreboard_drained", p, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
